// File: rtl/cva6_axi_resp_pkg.sv
// Shared types and encodings for the CVA6 AXI memory responder.
package cva6_axi_resp_pkg;

  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiAddrWidth = 64;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
  } axi_ax_req_t;

  // WRAP and the reserved encoding are refused, as is any beat wider than the bus.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst < BURST_WRAP) && (size <= 3'd3);
  endfunction

endpackage

// File: rtl/cva6_axi_resp_addr_gen.sv
// Next-beat address, range check, word index and burst legality for one AXI channel.
module cva6_axi_resp_addr_gen
  import cva6_axi_resp_pkg::*;
#(
  parameter logic [AxiAddrWidth-1:0] BaseAddr = 64'h8000_0000,
  parameter int unsigned             MemWords = 1024,
  parameter int unsigned             IdxWidth = $clog2(MemWords)
) (
  input  logic [AxiAddrWidth-1:0] addr,
  input  logic [2:0]              size,
  input  logic [1:0]              burst,
  output logic [AxiAddrWidth-1:0] next_addr_c,
  output logic [IdxWidth-1:0]     idx_c,
  output logic                    in_range_c,
  output logic                    legal_c
);

  localparam logic [AxiAddrWidth-1:0] MemBytes = AxiAddrWidth'(MemWords) << 3;

  logic [AxiAddrWidth-1:0] offset;

  assign offset      = addr - BaseAddr;
  assign in_range_c  = (addr >= BaseAddr) && (offset < MemBytes);
  assign legal_c     = burst_legal(burst, size);
  assign idx_c       = offset[IdxWidth+2:3];
  assign next_addr_c = (burst == BURST_INCR) ? addr + (AxiAddrWidth'(1) << size) : addr;

endmodule

// File: rtl/cva6_axi_mem_responder.sv
// AXI4 responder backed by a 64-bit word memory for CVA6 fetch/load/store/LR-SC traffic.
// Optional exclusive monitor: define CVA6_AXI_RESP_EXCL_EN.
module cva6_axi_mem_responder
  import cva6_axi_resp_pkg::*;
#(
  parameter int unsigned IdWidth   = AxiIdWidth,
  parameter int unsigned AddrWidth = AxiAddrWidth,
  parameter int unsigned DataWidth = 64,
  parameter logic [63:0] BaseAddr  = 64'h8000_0000,
  parameter int unsigned MemWords  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic                   aw_lock_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  input  logic                   ar_lock_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = $clog2(MemWords);

  logic [DataWidth-1:0] mem [MemWords];

  w_state_e    w_state;
  r_state_e    r_state;
  axi_ax_req_t w_req;
  axi_ax_req_t r_req;
  logic [7:0]  w_cnt;
  logic [7:0]  r_cnt;
  logic [1:0]  w_resp;

  logic [AxiAddrWidth-1:0] w_next_addr, r_next_addr;
  logic [IdxWidth-1:0]     w_idx, r_idx;
  logic                    w_in_range, w_legal, r_in_range, r_legal;
  logic                    w_ok, r_ok, w_beat, mem_we;
  logic                    w_excl, w_excl_hit;
  logic [1:0]              w_resp_nxt, r_okay_code;

  cva6_axi_resp_addr_gen #(
    .BaseAddr (BaseAddr),
    .MemWords (MemWords),
    .IdxWidth (IdxWidth)
  ) u_w_addr (
    .addr        (w_req.addr),
    .size        (w_req.size),
    .burst       (w_req.burst),
    .next_addr_c (w_next_addr),
    .idx_c       (w_idx),
    .in_range_c  (w_in_range),
    .legal_c     (w_legal)
  );

  cva6_axi_resp_addr_gen #(
    .BaseAddr (BaseAddr),
    .MemWords (MemWords),
    .IdxWidth (IdxWidth)
  ) u_r_addr (
    .addr        (r_req.addr),
    .size        (r_req.size),
    .burst       (r_req.burst),
    .next_addr_c (r_next_addr),
    .idx_c       (r_idx),
    .in_range_c  (r_in_range),
    .legal_c     (r_legal)
  );

  assign w_ok   = w_in_range && w_legal;
  assign r_ok   = r_in_range && r_legal;
  assign w_beat = rst_ni && w_ready_o && w_valid_i;
  // A failed exclusive write leaves memory untouched.
  assign mem_we = w_beat && w_ok && (!w_excl || w_excl_hit);

  assign w_resp_nxt = !w_ok                                            ? RESP_SLVERR :
                      (w_excl && w_excl_hit && w_resp != RESP_SLVERR) ? RESP_EXOKAY :
                                                                        w_resp;

`ifdef CVA6_AXI_RESP_EXCL_EN
  logic                  mon_valid;
  logic [AxiIdWidth-1:0] mon_id;
  logic [IdxWidth-1:0]   mon_idx;
  logic                  mon_set, mon_clr;

  assign w_excl      = w_req.lock;
  assign w_excl_hit  = mon_valid && (mon_id == w_req.id) && (mon_idx == w_idx);
  assign r_okay_code = r_req.lock ? RESP_EXOKAY : RESP_OKAY;
  assign mon_set     = (r_state == R_FETCH) && r_req.lock && r_ok;
  assign mon_clr     = w_beat && w_ok &&
                       (w_excl ? w_excl_hit : (mon_valid && (mon_idx == w_idx)));

  // Clearing wins over a same-cycle reservation: the fetch saw pre-write data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mon_valid <= 1'b0;
      mon_id    <= '0;
      mon_idx   <= '0;
    end else if (mon_clr) begin
      mon_valid <= 1'b0;
    end else if (mon_set) begin
      mon_valid <= 1'b1;
      mon_id    <= r_req.id;
      mon_idx   <= r_idx;
    end
  end
`else
  logic unused_lock;

  assign w_excl      = 1'b0;
  assign w_excl_hit  = 1'b0;
  assign r_okay_code = RESP_OKAY;
  assign unused_lock = w_req.lock ^ r_req.lock;
`endif

  // Byte-strobed memory write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (w_strb_i[b]) mem[w_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_o <= 1'b1;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
      b_resp_o   <= RESP_OKAY;
      w_req      <= '0;
      w_cnt      <= '0;
      w_resp     <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_valid_i) begin
            w_req      <= '{id: AxiIdWidth'(aw_id_i), addr: AxiAddrWidth'(aw_addr_i),
                            len: aw_len_i, size: aw_size_i, burst: aw_burst_i, lock: aw_lock_i};
            w_cnt      <= '0;
            w_resp     <= RESP_OKAY;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i) begin
            w_resp     <= w_resp_nxt;
            w_cnt      <= w_cnt + 8'd1;
            w_req.addr <= w_next_addr;
            if (w_last_i || (w_cnt == w_req.len)) begin
              w_ready_o <= 1'b0;
              b_valid_o <= 1'b1;
              b_id_o    <= IdWidth'(w_req.id);
              b_resp_o  <= w_resp_nxt;
              w_state   <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: one fetch cycle per beat, then hold until accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_id_o     <= '0;
      r_data_o   <= '0;
      r_resp_o   <= RESP_OKAY;
      r_last_o   <= 1'b0;
      r_req      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid_i) begin
            r_req      <= '{id: AxiIdWidth'(ar_id_i), addr: AxiAddrWidth'(ar_addr_i),
                            len: ar_len_i, size: ar_size_i, burst: ar_burst_i, lock: ar_lock_i};
            r_cnt      <= '0;
            ar_ready_o <= 1'b0;
            r_state    <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_data_o  <= r_ok ? mem[r_idx] : '0;
          r_resp_o  <= r_ok ? r_okay_code : RESP_SLVERR;
          r_last_o  <= (r_cnt == r_req.len);
          r_id_o    <= IdWidth'(r_req.id);
          r_valid_o <= 1'b1;
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (r_ready_i) begin
            r_valid_o <= 1'b0;
            if (r_last_o) begin
              ar_ready_o <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              r_req.addr <= r_next_addr;
              r_cnt      <= r_cnt + 8'd1;
              r_state    <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
// Directed self-checking bench for cva6_axi_mem_responder.
module tb_cva6_axi_mem_responder;

  localparam int Tmo = 100;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aw_valid = 1'b0, aw_ready, aw_lock = 1'b0;
  logic [3:0]  aw_id = '0;
  logic [63:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        b_valid, b_ready = 1'b0;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0, ar_ready, ar_lock = 1'b0;
  logic [3:0]  ar_id = '0;
  logic [63:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        r_valid, r_ready = 1'b0, r_last;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  int total = 0;
  int bad = 0;

  logic [63:0] wdata [4];
  logic [7:0]  wstrb [4];
  logic [63:0] rd_data [4];
  logic [1:0]  rd_resp [4];
  logic        rd_last [4];
  logic [1:0]  resp;

  always #5 clk = ~clk;

  cva6_axi_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst), .aw_lock_i(aw_lock),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst), .ar_lock_i(ar_lock),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic lock,
                           output logic [1:0] bresp);
    int n;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_lock = lock;
    aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < Tmo) begin @(posedge clk); #1; n++; end
    if (n == Tmo) chk("aw_timeout", 0, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = wdata[i]; w_strb = wstrb[i]; w_last = (i == int'(len)); w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < Tmo) begin @(posedge clk); #1; n++; end
      if (n == Tmo) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    chk("b_latency", b_valid, 1);
    n = 0;
    while (!b_valid && n < Tmo) begin @(posedge clk); #1; n++; end
    if (n == Tmo) chk("b_timeout", 0, 1);
    chk("b_id", b_id, id);
    bresp = b_resp;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    chk("aw_ready_b2b", aw_ready, 1);
  endtask

  // stall holds r_ready low for that many cycles on beat 0, checking data against hold_exp.
  task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic lock,
                          input int stall, input logic [63:0] hold_exp);
    int n;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_lock = lock;
    ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < Tmo) begin @(posedge clk); #1; n++; end
    if (n == Tmo) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    chk("r_lat_n1", r_valid, 0);
    @(posedge clk); #1;
    chk("r_lat_n2", r_valid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!r_valid && n < Tmo) begin @(posedge clk); #1; n++; end
      if (n == Tmo) chk("r_timeout", 0, 1);
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          chk("r_hold_valid", r_valid, 1);
          chk("r_hold_data", r_data, hold_exp);
        end
      end
      rd_data[i] = r_data; rd_resp[i] = r_resp; rd_last[i] = r_last;
      chk("r_id", r_id, id);
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
    end
    chk("ar_ready_b2b", ar_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // single INCR write and readback
    wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
    axi_write(4'd5, 64'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    chk("single_b_resp", resp, 0);
    axi_read(4'd6, 64'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("single_r_data", rd_data[0], 64'hDEAD_BEEF_0123_4567);
    chk("single_r_resp", rd_resp[0], 0);
    chk("single_r_last", rd_last[0], 1);

    // INCR len 3 with a partial strobe on beat 2
    wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrb[0] = 8'hFF;
    axi_write(4'd2, 64'h8000_0110, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    wdata[0] = 64'h1111_1111_1111_1111; wstrb[0] = 8'hFF;
    wdata[1] = 64'h2222_2222_2222_2222; wstrb[1] = 8'hFF;
    wdata[2] = 64'h3333_3333_3333_3333; wstrb[2] = 8'h0F;
    wdata[3] = 64'h4444_4444_4444_4444; wstrb[3] = 8'hFF;
    axi_write(4'd2, 64'h8000_0100, 8'd3, 3'd3, 2'd1, 1'b0, resp);
    chk("burst_b_resp", resp, 0);
    axi_read(4'd7, 64'h8000_0100, 8'd3, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("burst_d0", rd_data[0], 64'h1111_1111_1111_1111);
    chk("burst_d1", rd_data[1], 64'h2222_2222_2222_2222);
    chk("burst_d2", rd_data[2], 64'hAAAA_AAAA_3333_3333);
    chk("burst_d3", rd_data[3], 64'h4444_4444_4444_4444);
    chk("burst_last0", rd_last[0], 0);
    chk("burst_last2", rd_last[2], 0);
    chk("burst_last3", rd_last[3], 1);
    chk("burst_resp3", rd_resp[3], 0);

    // out of range below base and at the top boundary
    wdata[0] = 64'h0123_4567_89AB_CDEF; wstrb[0] = 8'hFF;
    axi_write(4'd1, 64'h8000_0000, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(4'd1, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    chk("oor_b_resp", resp, 2);
    axi_read(4'd1, 64'h8000_0000, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("oor_base_intact", rd_data[0], 64'h0123_4567_89AB_CDEF);
    axi_read(4'd1, 64'h8000_2000, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("oor_top_data", rd_data[0], 0);
    chk("oor_top_resp", rd_resp[0], 2);

    // illegal size write leaves memory alone
    wdata[0] = 64'h0; wstrb[0] = 8'hFF;
    axi_write(4'd4, 64'h8000_0010, 8'd0, 3'd4, 2'd1, 1'b0, resp);
    chk("size4_b_resp", resp, 2);

    // WRAP read: every beat refused
    axi_read(4'd9, 64'h8000_0010, 8'd1, 3'd3, 2'd2, 1'b0, 0, 64'h0);
    chk("wrap_d0", rd_data[0], 0);
    chk("wrap_r0", rd_resp[0], 2);
    chk("wrap_d1", rd_data[1], 0);
    chk("wrap_r1", rd_resp[1], 2);
    chk("wrap_last1", rd_last[1], 1);

    // backpressured read alongside an independent write
    wdata[0] = 64'h5555_6666_7777_8888; wstrb[0] = 8'hFF;
    fork
      axi_read(4'd8, 64'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b0, 5, 64'hDEAD_BEEF_0123_4567);
      axi_write(4'd3, 64'h8000_0200, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    join
    chk("conc_b_resp", resp, 0);
    axi_read(4'd8, 64'h8000_0200, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("conc_w_data", rd_data[0], 64'h5555_6666_7777_8888);

    // reset in the middle of a read burst
    ar_id = 4'd1; ar_addr = 64'h8000_0100; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'd1;
    ar_lock = 1'b0; ar_valid = 1'b1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_beat0_valid", r_valid, 1);
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_beat1_valid", r_valid, 1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_ar_ready", ar_ready, 1);
    rst_ni = 1'b1;
    axi_read(4'd2, 64'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("post_rst_data", rd_data[0], 64'hDEAD_BEEF_0123_4567);

    // exclusive pair, id 3
    wdata[0] = 64'h1; wstrb[0] = 8'hFF;
    axi_write(4'd1, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b1, 0, 64'h0);
    chk("ex_lr_data", rd_data[0], 64'h1);
    wdata[0] = 64'hCAFE;
    axi_write(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b1, resp);
`ifdef CVA6_AXI_RESP_EXCL_EN
    chk("ex_sc_resp", resp, 1);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("ex_sc_data", rd_data[0], 64'hCAFE);
    wdata[0] = 64'hBEEF;
    axi_write(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b1, resp);
    chk("ex_repeat_resp", resp, 0);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("ex_repeat_data", rd_data[0], 64'hCAFE);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b1, 0, 64'h0);
    wdata[0] = 64'h7777;
    axi_write(4'd5, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, resp);
    wdata[0] = 64'h9999;
    axi_write(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b1, resp);
    chk("ex_broken_resp", resp, 0);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("ex_broken_data", rd_data[0], 64'h7777);
`else
    chk("ex_unsup_resp", resp, 0);
    axi_read(4'd3, 64'h8000_0300, 8'd0, 3'd3, 2'd1, 1'b0, 0, 64'h0);
    chk("ex_unsup_data", rd_data[0], 64'hCAFE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cva6_axi_mem_responder.md
# cva6_axi_mem_responder

AXI4 subordinate (responder) backed by an internal word-addressed memory, terminating the AXI requests that the CVA6 core issues as initiator: 4-bit IDs, 64-bit addresses, 64-bit data. Sits on the testbench/SoC side of the core's NoC port and answers fetch, load, store and LR/SC traffic over one cached or uncached region. Read and write channels are serviced by independent state machines.

## Interface

- `IdWidth`, 4: AXI ID width.
- `AddrWidth`, 64: AXI address width.
- `DataWidth`, 64: AXI data width; fixed at 64, 8-byte words.
- `BaseAddr`, 64'h8000_0000: first byte address served.
- `MemWords`, 1024: memory depth in 64-bit words; power of two.

Ports:

- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. One clock; reset is synchronous and active-low.
- `aw_valid_i` / `aw_ready_o`  in/out  1: write-address handshake.
- `aw_id_i`  in  IdWidth: write ID.
- `aw_addr_i`  in  AddrWidth: write address.
- `aw_len_i`  in  8: beats minus 1.
- `aw_size_i`  in  3: bytes per beat, log2.
- `aw_burst_i`  in  2: burst type.
- `aw_lock_i`  in  1: exclusive access.
- `w_valid_i` / `w_ready_o`  in/out  1: write-data handshake.
- `w_data_i`  in  64: write data.
- `w_strb_i`  in  8: byte strobes.
- `w_last_i`  in  1: last beat.
- `b_valid_o` / `b_ready_i`  out/in  1: write-response handshake.
- `b_id_o`  out  IdWidth: response ID.
- `b_resp_o`  out  2: response code.
- `ar_valid_i` / `ar_ready_o`  in/out  1: read-address handshake.
- `ar_id_i`, `ar_addr_i`, `ar_len_i`, `ar_size_i`, `ar_burst_i`, `ar_lock_i`  in: same meaning as the AW fields.
- `r_valid_o` / `r_ready_i`  out/in  1: read-data handshake.
- `r_id_o`  out  IdWidth: read ID.
- `r_data_o`  out  64: read data.
- `r_resp_o`  out  2: response code.
- `r_last_o`  out  1: last beat.

## Operation

- Response codes: OKAY=0, EXOKAY=1, SLVERR=2.
- Word index: `(addr - BaseAddr) >> 3`. A beat is in range iff `BaseAddr <= addr < BaseAddr + 8*MemWords`.
- Next beat address:
  - FIXED (0): address unchanged.
  - INCR (1): address + `(1 << size)`, full 64-bit wrap.
  - WRAP (2) and reserved (3): every beat returns SLVERR, no memory write, read data 0.
- Size > 3: same treatment as WRAP — every beat SLVERR, no write, read data 0.
- Write FSM:
  - W_IDLE: `aw_ready_o=1`. AW handshake latches id/addr/len/size/burst/lock → W_DATA.
  - W_DATA: `w_ready_o=1`. Each beat writes the strobe-selected bytes if in range and the burst is legal.
  - Any bad beat makes the burst response sticky SLVERR.
  - On the beat with `w_last_i=1`, or when the beat counter reaches len, → W_RESP. A w_last mismatch leaves the response unchanged.
  - W_RESP: `b_valid_o=1` until `b_ready_i`, then → W_IDLE.
- Read FSM:
  - R_IDLE: `ar_ready_o=1`. AR handshake latches fields → R_FETCH.
  - R_FETCH: registers `mem[idx]` (or 0 if out of range or illegal) and the per-beat resp → R_DATA.
  - R_DATA: `r_valid_o=1` and outputs stable until `r_ready_i`.
  - On the handshake: if the beat was last → R_IDLE, else advance the address → R_FETCH.
  - `r_last_o` = (beat counter == len).
- Same-cycle write and R_FETCH to the same word: the fetch returns the old data; the write commits at the clock edge.

## Timing

- Reset values: all valid outputs 0; `aw_ready_o` 1; `ar_ready_o` 1; `w_ready_o` 0; ids/data/resp/last 0. FSMs go to IDLE, the reservation is cleared, memory contents are not reset.
- Reset asserted mid-burst: the burst is abandoned; no B or R is issued for it.
- Read latency: AR handshake at cycle N → `r_valid_o` at N+2; a burst delivers at most one beat every 2 cycles.
- Write: the AW handshake at N makes `w_ready_o` high from N+1; the last W beat at M gives `b_valid_o` at M+1.
- Back-to-back: next AW or AR acceptance the cycle after the B or final R handshake.
- One outstanding transaction per channel; read and write proceed concurrently.

## Configuration

- Macro: `CVA6_AXI_RESP_EXCL_EN`.
- Defined — single-entry exclusive monitor holding {valid, id, word index}:
  - An in-range exclusive read (`ar_lock_i`) sets the monitor.
  - An exclusive write with matching valid/id/index writes memory, responds EXOKAY, and clears the monitor.
  - An exclusive write without a match performs no memory write and responds OKAY.
  - Any non-exclusive write to the monitored word clears the monitor.
- Undefined: the lock field is ignored and exclusive accesses behave as normal accesses with OKAY, signalling to the initiator that exclusives are unsupported (the SC fails).

## Structure

- Shared package `cva6_axi_resp_pkg`:
  - resp codes `RESP_OKAY` / `RESP_EXOKAY` / `RESP_SLVERR`;
  - burst encodings;
  - `w_state_e` / `r_state_e` enums;
  - `axi_ax_req_t` latched-request struct.
- Sub-module `cva6_axi_resp_addr_gen`: combinational next-address, range check, word index and legality, instantiated once for the write path and once for the read path.

## Test plan

- Single INCR write: `aw_addr=0x8000_0010`, len 0, size 3, data `0xDEAD_BEEF_0123_4567`, strb `0xFF` → B OKAY with matching id; a later read of the same address returns the same data, OKAY, `r_last_o=1`, with `r_valid_o` two cycles after AR.
- INCR len 3 write with strb `0x0F` on beat 2, then a read burst → four words; beat 2 has only the low 4 bytes updated, and `r_last_o` is high only on beat 3.
- Out of range: `aw_addr=0x7FFF_FFF8` → B SLVERR and the memory word at `BaseAddr` is untouched. Read of `BaseAddr + 8*MemWords` → data 0, SLVERR.
- WRAP burst (`burst=2`) read, len 1 → two beats, each SLVERR, data 0.
- Backpressure and concurrency:
  - `r_ready_i` low for 5 cycles → `r_*` held stable.
  - A concurrent write to another address completes independently.
  - `rst_ni` low mid-read-burst → `r_valid_o=0` the next cycle and `ar_ready_o=1`.
- With `CVA6_AXI_RESP_EXCL_EN`:
  - Exclusive read then exclusive write, id 3 → EXOKAY and data written.
  - A repeat exclusive write → OKAY, no write.
  - An intervening normal write to the monitored word before the exclusive write → OKAY, no write.
